// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared types and constants for the 2-input gate BIST.
//   state_t  : controller states
//   vec_at() : Gray-ordered vector sequence {A,B} = 00,10,11,01
//   TT_*     : expected truth tables, bit i = y for {A,B} = i
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Vector index sequence, one input toggles per step
  localparam logic [1:0] VEC_SEQ [4] = '{2'd0, 2'd2, 2'd3, 2'd1};

  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;

  function automatic logic [1:0] vec_at(input logic [1:0] idx);
    logic [1:0] v;
    case (idx)
      2'd0:    v = VEC_SEQ[0];
      2'd1:    v = VEC_SEQ[1];
      2'd2:    v = VEC_SEQ[2];
      default: v = VEC_SEQ[3];
    endcase
    return v;
  endfunction

endpackage

// File: rtl/gate_nand.sv
// gate_nand: 2-input NAND, the reference gate exercised by gate_bist.
//   a, b : inputs
//   y    : ~(a & b)
module gate_nand (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

// File: rtl/gate_bist.sv
// gate_bist: self-test controller for a 2-input combinational gate.
// Sweeps {A,B} through 00,10,11,01, holding each for SETTLE_CYCLES and
// sampling y_in on the last held cycle, then checks against EXP_TRUTH.
//
// state | meaning
// IDLE  | waiting for start; results from the last run held
// DRIVE | applying vectors and sampling y_in
// DONE  | one-cycle done pulse; cont selects rerun or idle
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, cont       : begin a run (IDLE only), continuous rerun (DONE only)
//   y_in              : gate under test output
//   a_out, b_out      : gate under test inputs
//   busy, done        : run in progress, end-of-run pulse
//   pass              : last completed run and all since start were clean
//   fail_mask, err_cnt: per-combination fail flags, saturating error count
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [3:0]  EXP_TRUTH     = TT_NAND,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             y_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       fail_mask,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             a_q, a_d, b_q, b_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [3:0]       mask_q, mask_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic       sample_edge, last_vec, mismatch;
  logic [3:0] mask_hit;

  assign sample_edge = (state_q == DRIVE) && (cnt_q == CNT_LAST);
  assign last_vec    = (idx_q == 2'd3);
  assign mismatch    = (y_in != EXP_TRUTH[{a_q, b_q}]);
  assign mask_hit    = (sample_edge && mismatch) ? (4'b0001 << {a_q, b_q}) : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mask_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   if (sample_edge && last_vec) state_d = DONE;
      DONE:    state_d = cont ? DRIVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    a_d    = a_q;
    b_d    = b_q;
    busy_d = busy_q;
    done_d = 1'b0;
    pass_d = pass_q;
    mask_d = mask_q;
    err_d  = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d  = '0;
          idx_d  = '0;
          a_d    = 1'b0;
          b_d    = 1'b0;
          busy_d = 1'b1;
          pass_d = 1'b0;
          mask_d = '0;
          err_d  = '0;
        end
      end
      DRIVE: begin
        if (sample_edge) begin
          mask_d = mask_q | mask_hit;
          if (mismatch && (err_q != {ERR_W{1'b1}})) err_d = err_q + 1'b1;
          cnt_d = '0;
          if (last_vec) begin
            idx_d  = '0;
            a_d    = 1'b0;
            b_d    = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b1;
            // mask accumulates since start, so clean mask covers both this run and earlier ones
            pass_d = ((mask_q | mask_hit) == 4'b0000);
          end else begin
            idx_d      = idx_q + 2'd1;
            {a_d, b_d} = vec_at(idx_q + 2'd1);
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        cnt_d  = '0;
        idx_d  = '0;
        a_d    = 1'b0;
        b_d    = 1'b0;
        busy_d = cont;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = mask_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_gate_bist.sv
// tb_gate_bist: directed, table-driven checks of gate_bist.
//   u1: SETTLE_CYCLES=1, ERR_W=8, y_in selectable (nand / tied 1 / tied 0)
//   u2: SETTLE_CYCLES=1, ERR_W=2, y_in tied 0, continuous mode
//   u3: SETTLE_CYCLES=3, nand output inverted on non-sampling cycles
module tb_gate_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- u1 ----------------
  logic       rst1 = 1'b1, start1 = 1'b0, cont1 = 1'b0;
  int         ymode1 = 0;
  logic       yn1, y1, a1, b1, busy1, done1, pass1;
  logic [3:0] mask1;
  logic [7:0] err1;

  gate_nand g1 (.a(a1), .b(b1), .y(yn1));
  assign y1 = (ymode1 == 0) ? yn1 : (ymode1 == 1) ? 1'b1 : 1'b0;

  gate_bist #(.SETTLE_CYCLES(1), .EXP_TRUTH(4'b0111), .ERR_W(8)) u1 (
    .clk(clk), .rst(rst1), .start(start1), .cont(cont1), .y_in(y1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_mask(mask1), .err_cnt(err1));

  // ---------------- u2 ----------------
  logic       rst2 = 1'b1, start2 = 1'b0, cont2 = 1'b0;
  logic       a2, b2, busy2, done2, pass2;
  logic [3:0] mask2;
  logic [1:0] err2;

  gate_bist #(.SETTLE_CYCLES(1), .EXP_TRUTH(4'b0111), .ERR_W(2)) u2 (
    .clk(clk), .rst(rst2), .start(start2), .cont(cont2), .y_in(1'b0),
    .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_mask(mask2), .err_cnt(err2));

  // ---------------- u3 ----------------
  logic       rst3 = 1'b1, start3 = 1'b0, glitch3 = 1'b0;
  logic       yn3, y3, a3, b3, busy3, done3, pass3;
  logic [3:0] mask3;
  logic [7:0] err3;

  gate_nand g3 (.a(a3), .b(b3), .y(yn3));
  assign y3 = yn3 ^ glitch3;

  gate_bist #(.SETTLE_CYCLES(3), .EXP_TRUTH(4'b0111), .ERR_W(8)) u3 (
    .clk(clk), .rst(rst3), .start(start3), .cont(1'b0), .y_in(y3),
    .a_out(a3), .b_out(b3), .busy(busy3), .done(done3), .pass(pass3),
    .fail_mask(mask3), .err_cnt(err3));

  typedef struct {
    int         mode;
    logic       pass;
    logic [3:0] mask;
    logic [7:0] err;
  } vec_t;

  logic [1:0] seq [4];

  // One u1 run; start sampled at edge 0, samples at edges 1..4, done in cycle 5.
  task automatic run1(input int mode, input logic ep, input logic [3:0] em, input logic [7:0] ee);
    @(negedge clk);
    ymode1 = mode;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("u1_busy", 32'(busy1), 32'd1);
      chk("u1_ab", 32'({a1, b1}), 32'(seq[c-1]));
      chk("u1_done_early", 32'(done1), 32'd0);
      if (c == 1) begin
        chk("u1_pass_clr", 32'(pass1), 32'd0);
        chk("u1_mask_clr", 32'(mask1), 32'd0);
        chk("u1_err_clr", 32'(err1), 32'd0);
      end
      @(negedge clk);
    end
    chk("u1_done", 32'(done1), 32'd1);
    chk("u1_busy_end", 32'(busy1), 32'd0);
    chk("u1_ab_end", 32'({a1, b1}), 32'd0);
    chk("u1_pass", 32'(pass1), 32'(ep));
    chk("u1_mask", 32'(mask1), 32'(em));
    chk("u1_err", 32'(err1), 32'(ee));
    @(negedge clk);
    chk("u1_done_1cyc", 32'(done1), 32'd0);
    chk("u1_idle_busy", 32'(busy1), 32'd0);
    chk("u1_pass_hold", 32'(pass1), 32'(ep));
    chk("u1_err_hold", 32'(err1), 32'(ee));
  endtask

  initial begin
    vec_t tbl [5];
    seq[0] = 2'd0; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd1;
    tbl[0] = '{0, 1'b1, 4'b0000, 8'd0};
    tbl[1] = '{1, 1'b0, 4'b1000, 8'd1};
    tbl[2] = '{2, 1'b0, 4'b0111, 8'd3};
    tbl[3] = '{0, 1'b1, 4'b0000, 8'd0};
    tbl[4] = '{1, 1'b0, 4'b1000, 8'd1};

    repeat (2) @(negedge clk);
    rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_ab", 32'({a1, b1}), 32'd0);
    chk("rst_pass", 32'(pass1), 32'd0);
    chk("rst_mask", 32'(mask1), 32'd0);
    chk("rst_err", 32'(err1), 32'd0);
    chk("rst_busy3", 32'(busy3), 32'd0);

    // Table-driven single runs on u1
    for (int i = 0; i < 5; i++) run1(tbl[i].mode, tbl[i].pass, tbl[i].mask, tbl[i].err);

    // start while busy is ignored; run length unchanged
    @(negedge clk);
    ymode1 = 0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("busy_start_busy", 32'(busy1), 32'd1);
      chk("busy_start_done", 32'(done1), 32'd0);
      start1 = (c == 2);
      @(negedge clk);
    end
    start1 = 1'b0;
    chk("busy_start_donepulse", 32'(done1), 32'd1);
    chk("busy_start_pass", 32'(pass1), 32'd1);
    // start presented during DONE is ignored
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("done_start_busy", 32'(busy1), 32'd0);
    @(negedge clk);
    chk("done_start_busy2", 32'(busy1), 32'd0);

    // Reset in the 3rd vector with errors already counted
    ymode1 = 2;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_ab", 32'({a1, b1}), 32'd3);
    chk("pre_rst_err", 32'(err1), 32'd2);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    chk("mid_rst_busy", 32'(busy1), 32'd0);
    chk("mid_rst_ab", 32'({a1, b1}), 32'd0);
    chk("mid_rst_err", 32'(err1), 32'd0);
    chk("mid_rst_mask", 32'(mask1), 32'd0);
    for (int c = 0; c < 6; c++) begin
      chk("mid_rst_nodone", 32'(done1), 32'd0);
      @(negedge clk);
    end

    // Settle of 3 with wrong y_in on every non-sampling cycle
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      glitch3 = ((c % 3) != 0);
      chk("s3_busy", 32'(busy3), 32'd1);
      chk("s3_ab", 32'({a3, b3}), 32'(seq[(c-1)/3]));
      chk("s3_done_early", 32'(done3), 32'd0);
      @(negedge clk);
    end
    glitch3 = 1'b0;
    chk("s3_done", 32'(done3), 32'd1);
    chk("s3_busy_end", 32'(busy3), 32'd0);
    chk("s3_pass", 32'(pass3), 32'd1);
    chk("s3_err", 32'(err3), 32'd0);
    chk("s3_mask", 32'(mask3), 32'd0);

    // Continuous mode with saturation at 3; cont drops in the 4th run
    cont2 = 1'b1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 17) cont2 = 1'b0;
      chk("cont_done", 32'(done2), 32'((c % 5 == 0) && (c <= 20)));
      chk("cont_busy", 32'(busy2), 32'((c < 20) && (c % 5 != 0)));
      if (c == 2) chk("cont_err_r1a", 32'(err2), 32'd1);
      if (c == 4) chk("cont_err_r1b", 32'(err2), 32'd2);
      if (c == 5) chk("cont_err_r1", 32'(err2), 32'd3);
      if (c == 7) chk("cont_err_sat", 32'(err2), 32'd3);
      if (c == 7) chk("cont_mask_acc", 32'(mask2), 32'd7);
      if (c % 5 == 0 && c <= 20) begin
        chk("cont_err_done", 32'(err2), 32'd3);
        chk("cont_mask_done", 32'(mask2), 32'd7);
        chk("cont_pass_done", 32'(pass2), 32'd0);
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
